// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU round-robin arbiter.
package alu_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    S_OPEN   = 1'b0,
    S_LOCKED = 1'b1
  } arb_state_t;

  // Round-robin successor of ptr, wrapping from num_req-1 back to 0.
  function automatic int unsigned next_rr_idx(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after i_ptr,
// wrapping, where eligible means requesting and not masked off.
module rr_pick #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITS-1:0] i_ptr,
  input  logic [NUM_REQ-1:0]  i_mask,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [IDX_BITS-1:0] o_idx,
  output logic                o_valid
);

  localparam int unsigned CW = IDX_BITS + 1;

  logic [NUM_REQ-1:0] w_elig;
  logic [CW-1:0]      w_cand;

  assign w_elig = i_req & i_mask;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = CW'(i_ptr) + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!o_valid && w_elig[w_cand[IDX_BITS-1:0]]) begin
        o_valid                          = 1'b1;
        o_idx                            = w_cand[IDX_BITS-1:0];
        o_grant[w_cand[IDX_BITS-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered add/sub ALU between NUM_REQ requesters.
// Optional grant locking for multi-op sequences is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned REQ_IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_sub,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_a,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_b,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_result,
  output logic                           rsp_cout,
  output logic                           rsp_zero,
  output logic [DATA_BITS-1:0]           alu_a,
  output logic [DATA_BITS-1:0]           alu_b,
  output logic                           alu_cin,
  input  logic [DATA_BITS-1:0]           alu_result,
  input  logic                           alu_cout,
  input  logic                           alu_zero
);

  logic [REQ_IDX_BITS-1:0] r_rr_ptr;
  logic                    r_inflight_valid;
  logic [REQ_IDX_BITS-1:0] r_inflight_tag;

  logic [NUM_REQ-1:0]      w_mask;
  logic [NUM_REQ-1:0]      w_grant;
  logic [REQ_IDX_BITS-1:0] w_idx;
  logic                    w_pick_valid;
  logic                    w_accept;
  logic [REQ_IDX_BITS-1:0] w_ptr_nxt;
  logic [REQ_IDX_BITS-1:0] w_ptr_win;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (REQ_IDX_BITS)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_pick_valid)
  );

  // Grant is suppressed while reset is held so ready/ALU drive drop immediately.
  assign w_accept  = reset_n & w_pick_valid;
  assign w_ptr_win = REQ_IDX_BITS'(next_rr_idx(32'(w_idx), NUM_REQ));

`ifdef ALU_ARB_LOCK_EN
  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [REQ_IDX_BITS-1:0] r_owner;
  logic [REQ_IDX_BITS-1:0] w_owner_nxt;
  logic [REQ_IDX_BITS-1:0] w_ptr_own;

  assign w_ptr_own = REQ_IDX_BITS'(next_rr_idx(32'(r_owner), NUM_REQ));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_OPEN;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // While locked only the owner is eligible.
  always_comb begin
    w_mask = '1;
    if (r_state == S_LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  // Lock exits on an unlocking owner op or when the owner drops valid.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_rr_ptr;
    case (r_state)
      S_OPEN: begin
        if (w_accept) begin
          w_ptr_nxt = w_ptr_win;
          if (req_lock[w_idx]) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_idx;
          end
        end
      end
      S_LOCKED: begin
        if (!req_valid[r_owner] || (w_accept && !req_lock[r_owner])) begin
          w_state_nxt = S_OPEN;
          w_ptr_nxt   = w_ptr_own;
        end
      end
      default: begin
        w_state_nxt = S_OPEN;
      end
    endcase
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_mask        = '1;

  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      w_ptr_nxt = w_ptr_win;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr         <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_tag   <= '0;
    end else begin
      r_rr_ptr         <= w_ptr_nxt;
      r_inflight_valid <= w_accept;
      if (w_accept) begin
        r_inflight_tag <= w_idx;
      end
    end
  end

  // Winner's operands go straight to the ALU, which registers them on the accepting edge.
  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    if (w_accept) begin
      req_ready = w_grant;
      alu_a     = req_a[32'(w_idx)*DATA_BITS +: DATA_BITS];
      alu_b     = req_b[32'(w_idx)*DATA_BITS +: DATA_BITS];
      alu_cin   = req_sub[w_idx];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_inflight_valid) begin
      rsp_valid[r_inflight_tag] = 1'b1;
    end
  end

  assign rsp_result = alu_result;
  assign rsp_cout   = alu_cout;
  assign rsp_zero   = alu_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered add/sub ALU model attached.
module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_sub;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        alu_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(
    .DATA_BITS (8),
    .NUM_REQ   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_lock   (req_lock),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: sub is a + ~b + 1.
  logic [8:0] alu_sum;
  always_comb alu_sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + 9'(alu_cin);
  always_ff @(posedge clk) begin
    alu_result <= alu_sum[7:0];
    alu_cout   <= alu_sum[8];
    alu_zero   <= (alu_sum[7:0] == 8'h00);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] valid;
    logic [1:0] sub;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] exp_ready;
    logic [7:0] exp_a, exp_b;
    logic       exp_cin;
    logic [1:0] exp_rsp;
    logic [7:0] exp_res;
    logic       exp_cout, exp_zero;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] s,
                              input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1,
                              input logic [1:0] er, input logic [7:0] ea,
                              input logic [7:0] eb, input logic ec,
                              input logic [1:0] ersp, input logic [7:0] eres,
                              input logic ecout, input logic ezero);
    vec_t t;
    t.valid = v;  t.sub = s;
    t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1;
    t.exp_ready = er; t.exp_a = ea; t.exp_b = eb; t.exp_cin = ec;
    t.exp_rsp = ersp; t.exp_res = eres; t.exp_cout = ecout; t.exp_zero = ezero;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input logic [1:0] lk);
    req_valid = v;
    req_sub   = s;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_lock  = lk;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t       tbl [13];
  logic [1:0] lock_exp [5];
  logic [1:0] ab_exp [3];
  int         ops;

  initial begin
    tbl[0]  = mk(2'b01, 2'b00, 8'h7F, 8'h01, 8'h00, 8'h00, 2'b01, 8'h7F, 8'h01, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    tbl[1]  = mk(2'b11, 2'b11, 8'h05, 8'h05, 8'h05, 8'h05, 2'b10, 8'h05, 8'h05, 1'b1, 2'b01, 8'h80, 1'b0, 1'b0);
    tbl[2]  = mk(2'b11, 2'b11, 8'h05, 8'h05, 8'h05, 8'h05, 2'b01, 8'h05, 8'h05, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1);
    tbl[3]  = mk(2'b11, 2'b11, 8'h05, 8'h05, 8'h05, 8'h05, 2'b10, 8'h05, 8'h05, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1);
    tbl[4]  = mk(2'b11, 2'b11, 8'h05, 8'h05, 8'h05, 8'h05, 2'b01, 8'h05, 8'h05, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1);
    tbl[5]  = mk(2'b10, 2'b00, 8'h00, 8'h00, 8'h10, 8'h20, 2'b10, 8'h10, 8'h20, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1);
    tbl[6]  = mk(2'b10, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h01, 2'b10, 8'hFF, 8'h01, 1'b0, 2'b10, 8'h30, 1'b0, 1'b0);
    tbl[7]  = mk(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1);
    tbl[8]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1);
    tbl[9]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    tbl[10] = mk(2'b11, 2'b01, 8'h03, 8'h05, 8'h01, 8'h01, 2'b01, 8'h03, 8'h05, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    tbl[11] = mk(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 8'hFE, 1'b0, 1'b0);
    tbl[12] = mk(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

`ifdef ALU_ARB_LOCK_EN
    lock_exp[0] = 2'b01; lock_exp[1] = 2'b01; lock_exp[2] = 2'b01;
    lock_exp[3] = 2'b10; lock_exp[4] = 2'b10;
    ab_exp[0] = 2'b01; ab_exp[1] = 2'b00; ab_exp[2] = 2'b10;
`else
    lock_exp[0] = 2'b01; lock_exp[1] = 2'b10; lock_exp[2] = 2'b01;
    lock_exp[3] = 2'b10; lock_exp[4] = 2'b01;
    ab_exp[0] = 2'b01; ab_exp[1] = 2'b10; ab_exp[2] = 2'b01;
`endif

    // Reset state: requests present while reset is held must not be granted.
    reset_n = 1'b0;
    drive(2'b11, 2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b00);
    repeat (2) @(negedge clk);
    #2;
    check("reset ready", 32'(req_ready), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset alu_a", 32'(alu_a), 32'h0);
    check("reset alu_b", 32'(alu_b), 32'h0);
    check("reset alu_cin", 32'(alu_cin), 32'h0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].sub, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, 2'b00);
      #2;
      check($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      check($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(tbl[i].exp_a));
      check($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(tbl[i].exp_b));
      check($sformatf("v%0d alu_cin", i), 32'(alu_cin), 32'(tbl[i].exp_cin));
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_rsp));
      if (tbl[i].exp_rsp != 2'b00) begin
        check($sformatf("v%0d rsp_result", i), 32'(rsp_result), 32'(tbl[i].exp_res));
        check($sformatf("v%0d rsp_cout", i), 32'(rsp_cout), 32'(tbl[i].exp_cout));
        check($sformatf("v%0d rsp_zero", i), 32'(rsp_zero), 32'(tbl[i].exp_zero));
      end
    end

    // Reset mid-flight: accepted op must never retire.
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h7F, 8'h01, 8'h00, 8'h00, 2'b00);
    #2;
    check("midrst pre ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #2;
    check("midrst inflight", 32'(rsp_valid), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst ready drop", 32'(req_ready), 32'h0);
    check("midrst rsp drop", 32'(rsp_valid), 32'h0);
    check("midrst alu_a drop", 32'(alu_a), 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check($sformatf("midrst no rsp %0d", k), 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    drive(2'b11, 2'b00, 8'h01, 8'h01, 8'h02, 8'h02, 2'b00);
    #2;
    check("midrst ptr zero", 32'(req_ready), 32'h1);

    // Lock sequence: requester 0 issues three ops locking the first two.
    do_reset();
    ops = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive({1'b1, (ops < 3)}, 2'b00, 8'(ops), 8'h01, 8'h40, 8'h02, {1'b0, (ops < 2)});
      #2;
      check($sformatf("lock grant %0d", c), 32'(req_ready), 32'(lock_exp[c]));
      check($sformatf("lock rsp %0d", c), 32'(rsp_valid), (c == 0) ? 32'h0 : 32'(lock_exp[c-1]));
      if (req_ready[0]) ops++;
    end

    // Lock abandon: owner drops valid for one cycle.
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h01, 8'h01, 8'h00, 8'h00, 2'b01);
    #2;
    check("abandon c0", 32'(req_ready), 32'(ab_exp[0]));
    @(negedge clk);
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h02, 8'h02, 2'b00);
    #2;
    check("abandon c1", 32'(req_ready), 32'(ab_exp[1]));
    @(negedge clk);
    drive(2'b11, 2'b00, 8'h01, 8'h01, 8'h02, 8'h02, 2'b00);
    #2;
    check("abandon c2", 32'(req_ready), 32'(ab_exp[2]));
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
